// File: rtl/staff_grid_pkg.sv
// ============================================================
// staff_grid_pkg : colour constants, pitch width and rgb type
// Rev 1.0
// ============================================================
`default_nettype none

package staff_grid_pkg;

  localparam int c_pitch_w = 4;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t c_bg   = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t c_line = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam rgb_t c_note = '{r: 4'hF, g: 4'h0, b: 4'h0};

endpackage

`default_nettype wire

// File: rtl/staff_note_store.sv
// ============================================================
// staff_note_store : note pitch store with append handshake,
// clear, and a per-frame latched display count
// Rev 1.0
// ============================================================
`default_nettype none

module staff_note_store
  import staff_grid_pkg::*;
#(
  parameter int NOTE_DEPTH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset_p,
  input  logic                                  frame_start,
  input  logic                                  note_valid,
  output logic                                  note_ready,
  input  logic [c_pitch_w-1:0]                  note_pitch,
  input  logic                                  clear_notes,
  output logic [$clog2(NOTE_DEPTH+1)-1:0]       disp_count,
  output logic [NOTE_DEPTH-1:0][c_pitch_w-1:0]  pitches
);

  localparam int CNT_W = $clog2(NOTE_DEPTH + 1);
  localparam int IDX_W = (NOTE_DEPTH > 1) ? $clog2(NOTE_DEPTH) : 1;

  logic [CNT_W-1:0]                     wr_count_d, wr_count_q;
  logic [CNT_W-1:0]                     disp_count_d, disp_count_q;
  logic [NOTE_DEPTH-1:0][c_pitch_w-1:0] mem_d, mem_q;
  logic                                 accept;

  assign note_ready = (wr_count_q < CNT_W'(NOTE_DEPTH));
  // A clear in the same cycle cancels the append entirely, storage included.
  assign accept     = note_valid && note_ready && !clear_notes;

  always_comb begin
    wr_count_d   = wr_count_q;
    disp_count_d = disp_count_q;
    mem_d        = mem_q;
    if (clear_notes) begin
      wr_count_d = '0;
    end else if (accept) begin
      wr_count_d = wr_count_q + CNT_W'(1);
    end
    if (accept) begin
      mem_d[wr_count_q[IDX_W-1:0]] = note_pitch;
    end
    if (frame_start) begin
      disp_count_d = wr_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      wr_count_q   <= '0;
      disp_count_q <= '0;
    end else begin
      wr_count_q   <= wr_count_d;
      disp_count_q <= disp_count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign disp_count = disp_count_q;
  assign pitches    = mem_q;

endmodule

`default_nettype wire

// File: rtl/staff_grid.sv
// ============================================================
// staff_grid : staff lines plus note squares, 2-cycle pixel pipe
// Option: STAFF_GRID_BLINK_EN blinks the newest displayed note
// Rev 1.0
// ============================================================
`default_nettype none

module staff_grid
  import staff_grid_pkg::*;
#(
  parameter int N_LINES      = 7,
  parameter int LINE_TOP     = 96,
  parameter int SPACING_LOG2 = 4,
  parameter int LINE_THICK   = 2,
  parameter int NOTE_DEPTH   = 8,
  parameter int NOTE_X0      = 64,
  parameter int NOTE_STEP    = 32,
  parameter int NOTE_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset_p,
  input  logic [11:0]          x,
  input  logic [10:0]          y,
  input  logic                 frame_start,
  input  logic                 note_valid,
  output logic                 note_ready,
  input  logic [c_pitch_w-1:0] note_pitch,
  input  logic                 clear_notes,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b
);

  localparam int CNT_W = $clog2(NOTE_DEPTH + 1);

  logic [CNT_W-1:0]                     disp_count;
  logic [NOTE_DEPTH-1:0][c_pitch_w-1:0] pitches;
  logic                                 hide_newest;

  staff_note_store #(
    .NOTE_DEPTH (NOTE_DEPTH)
  ) u_store (
    .clk         (clk),
    .reset_p     (reset_p),
    .frame_start (frame_start),
    .note_valid  (note_valid),
    .note_ready  (note_ready),
    .note_pitch  (note_pitch),
    .clear_notes (clear_notes),
    .disp_count  (disp_count),
    .pitches     (pitches)
  );

`ifdef STAFF_GRID_BLINK_EN
  logic [4:0] blink_d, blink_q;

  always_comb begin
    blink_d = blink_q;
    if (frame_start) begin
      blink_d = blink_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign hide_newest = blink_q[4];
`else
  assign hide_newest = 1'b0;
`endif

  logic line_hit_d, line_hit_q;
  logic note_hit_d, note_hit_q;
  rgb_t rgb_d, rgb_q;
  int   px, py, note_top, note_left;

  // Windows are compared in 32-bit signed space so they clip instead of wrapping.
  always_comb begin
    line_hit_d = 1'b0;
    note_hit_d = 1'b0;
    px         = int'(x);
    py         = int'(y);
    note_top   = 0;
    note_left  = 0;
    for (int k = 0; k < N_LINES; k++) begin
      if ((py >= LINE_TOP + (k << SPACING_LOG2)) &&
          (py <  LINE_TOP + (k << SPACING_LOG2) + LINE_THICK)) begin
        line_hit_d = 1'b1;
      end
    end
    for (int i = 0; i < NOTE_DEPTH; i++) begin
      note_top  = LINE_TOP + (int'(pitches[i]) << (SPACING_LOG2 - 1)) - NOTE_W / 2;
      note_left = NOTE_X0 + i * NOTE_STEP;
      if ((CNT_W'(i) < disp_count) &&
          !(hide_newest && (CNT_W'(i + 1) == disp_count)) &&
          (px >= note_left) && (px < note_left + NOTE_W) &&
          (py >= note_top)  && (py < note_top + NOTE_W)) begin
        note_hit_d = 1'b1;
      end
    end
  end

  always_comb begin
    rgb_d = c_bg;
    if (note_hit_q) begin
      rgb_d = c_note;
    end else if (line_hit_q) begin
      rgb_d = c_line;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      line_hit_q <= 1'b0;
      note_hit_q <= 1'b0;
      rgb_q      <= c_bg;
    end else begin
      line_hit_q <= line_hit_d;
      note_hit_q <= note_hit_d;
      rgb_q      <= rgb_d;
    end
  end

  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

endmodule

`default_nettype wire

// File: tb/tb_staff_grid.sv
// ============================================================
// tb_staff_grid : table vectors, corner sequences and random
// pixels against a rule-level model of the staff display
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module tb_staff_grid;

  localparam int LT = 96, SP = 16, TH = 2, NL = 7;
  localparam int DEPTH = 8, X0 = 64, XS = 32, NW = 8;

  logic        clk = 1'b0;
  logic        reset_p = 1'b1;
  logic [11:0] x = '0;
  logic [10:0] y = '0;
  logic        frame_start = 1'b0;
  logic        note_valid = 1'b0;
  logic        note_ready;
  logic [3:0]  note_pitch = '0;
  logic        clear_notes = 1'b0;
  logic [3:0]  vga_r, vga_g, vga_b;

  always #5 clk = ~clk;

  staff_grid dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .note_valid  (note_valid),
    .note_ready  (note_ready),
    .note_pitch  (note_pitch),
    .clear_notes (clear_notes),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b)
  );

  int vectors = 0;
  int miscompares = 0;

  int m_mem[DEPTH];
  int m_wr = 0, m_disp = 0, m_fc = 0;

  typedef struct {
    int          stage;
    int          px;
    int          py;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[18];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_rgb(int px, int py);
    bit note_hit, line_hit, vis;
    int top, left;
    note_hit = 0;
    line_hit = 0;
    for (int i = 0; i < m_disp; i++) begin
      top  = LT + m_mem[i] * (SP / 2) - NW / 2;
      left = X0 + i * XS;
      vis  = 1;
`ifdef STAFF_GRID_BLINK_EN
      if (i == m_disp - 1 && m_fc >= 16) vis = 0;
`endif
      if (vis && px >= left && px < left + NW && py >= top && py < top + NW) note_hit = 1;
    end
    if (py >= LT && (py - LT) / SP < NL && (py - LT) % SP < TH) line_hit = 1;
    if (note_hit) return 12'hF00;
    if (line_hit) return 12'h000;
    return 12'hFFF;
  endfunction

  task automatic check_pixel(string name, int px, int py, logic [11:0] exp);
    @(negedge clk);
    x = 12'(px);
    y = 11'(py);
    @(posedge clk);
    @(posedge clk);
    #1;
    check(name, {vga_r, vga_g, vga_b}, exp);
  endtask

  task automatic stream(string name, int n);
    logic [11:0] q[$];
    int px, py;
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) check(name, {vga_r, vga_g, vga_b}, q.pop_front());
      if (k < n) begin
        if (k % 8 == 7) begin
          px = int'($urandom_range(4095, 0));
          py = int'($urandom_range(2047, 0));
        end else begin
          px = int'($urandom_range(340, 40));
          py = int'($urandom_range(270, 80));
        end
        x = 12'(px);
        y = 11'(py);
        q.push_back(model_rgb(px, py));
      end
    end
  endtask

  task automatic append(int p);
    @(negedge clk);
    note_valid = 1'b1;
    note_pitch = 4'(p);
    check("note_ready", note_ready, m_wr < DEPTH);
    @(negedge clk);
    note_valid = 1'b0;
    if (m_wr < DEPTH) begin
      m_mem[m_wr] = p;
      m_wr++;
    end
  endtask

  task automatic clear();
    @(negedge clk);
    clear_notes = 1'b1;
    @(negedge clk);
    clear_notes = 1'b0;
    m_wr = 0;
    check("ready_after_clear", note_ready, 1);
  endtask

  task automatic frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    m_disp = m_wr;
    m_fc   = (m_fc + 1) % 32;
  endtask

  task automatic apply_stage(int s);
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].stage == s) begin
        check_pixel($sformatf("tbl%0d(%0d,%0d)", i, tbl[i].px, tbl[i].py),
                    tbl[i].px, tbl[i].py, tbl[i].exp);
      end
    end
  endtask

  initial begin
    int p;
    tbl[0]  = '{0, 300, 96,   12'h000};
    tbl[1]  = '{0, 300, 97,   12'h000};
    tbl[2]  = '{0, 300, 98,   12'hFFF};
    tbl[3]  = '{0, 300, 192,  12'h000};
    tbl[4]  = '{0, 300, 208,  12'hFFF};
    tbl[5]  = '{0, 300, 95,   12'hFFF};
    tbl[6]  = '{0, 300, 113,  12'h000};
    tbl[7]  = '{0, 4095, 2047, 12'hFFF};
    tbl[8]  = '{1, 64, 124,   12'hFFF};
    tbl[9]  = '{2, 64, 124,   12'hF00};
    tbl[10] = '{2, 71, 131,   12'hF00};
    tbl[11] = '{2, 72, 124,   12'hFFF};
    tbl[12] = '{2, 63, 124,   12'hFFF};
    tbl[13] = '{2, 64, 123,   12'hFFF};
    tbl[14] = '{2, 64, 132,   12'hFFF};
    tbl[15] = '{2, 64, 128,   12'hF00};
    tbl[16] = '{2, 96, 124,   12'hFFF};
    tbl[17] = '{2, 80, 128,   12'h000};
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;

    repeat (3) @(negedge clk);
    reset_p = 1'b0;
    #1;
    check("reset_rgb", {vga_r, vga_g, vga_b}, 12'hFFF);
    check("reset_ready", note_ready, 1);
    check("reset_disp", dut.u_store.disp_count_q, 0);
    check("reset_wr", dut.u_store.wr_count_q, 0);

    apply_stage(0);
    append(4);
    apply_stage(1);
    frame();
    apply_stage(2);

    // Fill to capacity, then try a ninth note.
    for (int i = 0; i < 7; i++) append(int'($urandom_range(15, 0)));
    @(negedge clk);
    check("full_ready", note_ready, 0);
    append(9);
    check("full_wr_held", dut.u_store.wr_count_q, 8);
    frame();
    stream("eight_notes", 200);
    clear();
    check("clear_wr", dut.u_store.wr_count_q, 0);

    // Clear and append on the same edge with wr_count=3.
    for (int i = 0; i < 3; i++) append(i + 1);
    @(negedge clk);
    clear_notes = 1'b1;
    note_valid  = 1'b1;
    note_pitch  = 4'(15 - m_mem[3]);
    @(negedge clk);
    clear_notes = 1'b0;
    note_valid  = 1'b0;
    m_wr = 0;
    check("collide_wr", dut.u_store.wr_count_q, 0);
    check("collide_mem3", dut.u_store.mem_q[3], m_mem[3]);
    check("collide_disp", dut.u_store.disp_count_q, 8);

    // frame_start coinciding with append, then with clear.
    append(2);
    append(6);
    @(negedge clk);
    frame_start = 1'b1;
    note_valid  = 1'b1;
    note_pitch  = 4'd10;
    @(negedge clk);
    frame_start = 1'b0;
    note_valid  = 1'b0;
    m_disp = m_wr;
    m_fc   = (m_fc + 1) % 32;
    m_mem[m_wr] = 10;
    m_wr++;
    check("fs_append_disp", dut.u_store.disp_count_q, 2);
    check("fs_append_wr", dut.u_store.wr_count_q, 3);
    stream("fs_append_pix", 100);
    @(negedge clk);
    frame_start = 1'b1;
    clear_notes = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    clear_notes = 1'b0;
    m_disp = m_wr;
    m_fc   = (m_fc + 1) % 32;
    m_wr   = 0;
    check("fs_clear_disp", dut.u_store.disp_count_q, 3);
    check("fs_clear_wr", dut.u_store.wr_count_q, 0);
    stream("fs_clear_pix", 100);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 12; k++) begin
        p = int'($urandom_range(11, 0));
        if (p == 0) clear();
        else if (p == 1) frame();
        else append(int'($urandom_range(15, 0)));
      end
      frame();
      stream($sformatf("rand%0d", r), 150);
    end

    // Reset in the middle of a frame with 5 notes on screen.
    clear();
    for (int i = 0; i < 5; i++) append(2 * i);
    frame();
    check_pixel("pre_reset_note4", 192, 158, 12'hF00);
    @(negedge clk);
    x = 12'd192;
    y = 11'd158;
    reset_p = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_rgb", {vga_r, vga_g, vga_b}, 12'hFFF);
    check("midreset_disp", dut.u_store.disp_count_q, 0);
    check("midreset_wr", dut.u_store.wr_count_q, 0);
    @(negedge clk);
    reset_p = 1'b0;
    m_wr = 0;
    m_disp = 0;
    m_fc = 0;
    check_pixel("post_reset_note4", 192, 158, 12'hFFF);
    check_pixel("post_reset_line", 192, 160, 12'h000);
    stream("post_reset", 100);

`ifdef STAFF_GRID_BLINK_EN
    append(3);
    append(5);
    frame();
    for (int f = 0; f < 33; f++) begin
      check_pixel($sformatf("blink_n1_fc%0d", m_fc), 96, 134, (m_fc < 16) ? 12'hF00 : 12'hFFF);
      check_pixel($sformatf("blink_n0_fc%0d", m_fc), 64, 118, 12'hF00);
      frame();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
